// File: rtl/priority_decode.sv
// ============================================================================
// priority_decode
// ----------------------------------------------------------------------------
// Sequential index-to-vector decoder, the inverse of the 255-bit priority
// encoder. A bit index (typically the MSB position reported by the encoder)
// is accepted over a valid/ready handshake. The block then emits the matching
// one-hot select vector, either as a single beat or as a descending walk from
// that index down to bit 0. The walk feeds bit-serial scalar loops
// (double-and-add / ladder) that start at the scalar's most significant set
// bit.
//
// Optional feature macro: PRIORITY_DECODE_THERM_EN
//   When defined, the extra output out_therm carries a thermometer mask with
//   bits cur..0 set. It is registered together with the other beat outputs
//   and matches the magnitude mask of the encoder input.
//
// Ports
//   clk         in   1   clock, all state changes on the rising edge
//   rst         in   1   synchronous, active-high reset
//   in_valid    in   1   request present
//   in_ready    out  1   block can accept a request (state IDLE)
//   in_idx      in   W   starting bit index
//   in_walk     in   1   1 = walk in_idx..0, 0 = single beat
//   out_valid   out  1   output beat present
//   out_ready   in   1   consumer accepts the beat
//   out_onehot  out  N   1 << cur (zero when no beat)
//   out_idx     out  W   current index cur (zero when no beat)
//   out_last    out  1   final beat of the transaction
//   busy        out  1   transaction in progress (state EMIT)
//   err         out  1   one-cycle pulse: out-of-range request was dropped
//   out_therm   out  N   (only with PRIORITY_DECODE_THERM_EN) bits cur..0 set
//
// Every output is a flop. Next-cycle output values are derived from the
// next-state values, so a beat is visible right after the accepting edge and
// holds unchanged while the consumer stalls.
// ============================================================================
module priority_decode #(
    parameter int N = 255,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_idx,
    input  logic         in_walk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_onehot,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         busy,
`ifdef PRIORITY_DECODE_THERM_EN
    output logic [N-1:0] out_therm,
`endif
    output logic         err
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Vector width widened by one bit so that an index equal to N (or above)
    // can be compared without truncating N itself.
    localparam logic [W:0]   N_EXT    = (W+1)'(N);
    localparam logic [W-1:0] IDX_ZERO = {W{1'b0}};
    localparam logic [W-1:0] IDX_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] VEC_ZERO = {N{1'b0}};

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------

    // One-hot select vector: only bit idx set.
    function automatic logic [N-1:0] onehot_of(input logic [W-1:0] idx);
        logic [N-1:0] v;
        v = VEC_ZERO;
        for (int i = 0; i < N; i++) begin
            v[i] = (W'(i) == idx);
        end
        return v;
    endfunction

`ifdef PRIORITY_DECODE_THERM_EN
    // Thermometer mask: bits idx..0 set. Written as a per-bit compare so that
    // idx = N-1 yields the all-ones vector without an (N+1)-bit intermediate.
    function automatic logic [N-1:0] therm_of(input logic [W-1:0] idx);
        logic [N-1:0] v;
        v = VEC_ZERO;
        for (int i = 0; i < N; i++) begin
            v[i] = (W'(i) <= idx);
        end
        return v;
    endfunction
`endif

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    state_t         state_q,      state_d;
    logic [W-1:0]   cur_q,        cur_d;
    logic           walk_q,       walk_d;

    logic           in_ready_q,   in_ready_d;
    logic           out_valid_q,  out_valid_d;
    logic [N-1:0]   out_onehot_q, out_onehot_d;
    logic [W-1:0]   out_idx_q,    out_idx_d;
    logic           out_last_q,   out_last_d;
    logic           busy_q,       busy_d;
    logic           err_q,        err_d;
`ifdef PRIORITY_DECODE_THERM_EN
    logic [N-1:0]   out_therm_q,  out_therm_d;
`endif

    // Combinational helpers
    logic           idx_oob_s;    // requested index is outside 0..N-1
    logic           accept_s;     // request handshake in IDLE
    logic           cur_last_s;   // beat currently presented is the final one
    logic           emit_next_s;  // EMIT is the next state

    // Out-of-range check on the incoming index, one bit wider than the index.
    always_comb begin
        idx_oob_s = ({1'b0, in_idx} >= N_EXT);
    end

    // Handshake and last-beat qualifiers for the current cycle.
    always_comb begin
        accept_s   = in_valid & in_ready_q;
        // A walk always terminates at index 0, so cur never wraps below 0.
        cur_last_s = (~walk_q) | (cur_q == IDX_ZERO);
    end

    // Next-state logic of the IDLE/EMIT controller.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        walk_d  = walk_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (idx_oob_s) begin
                        // Drop the request, report it, remain ready.
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                        cur_d   = in_idx;
                        walk_d  = in_walk;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                // in_valid is deliberately not looked at while emitting.
                if (out_ready) begin
                    if (cur_last_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        cur_d = cur_q - IDX_ONE;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle state.
                state_d = ST_IDLE;
                cur_d   = IDX_ZERO;
                walk_d  = 1'b0;
            end
        endcase
    end

    // Output next-values, derived from the next state so every output is a
    // flop yet already reflects the beat that will be on the bus next cycle.
    always_comb begin
        emit_next_s  = (state_d == ST_EMIT);
        in_ready_d   = ~emit_next_s;
        out_valid_d  = emit_next_s;
        busy_d       = emit_next_s;
        out_onehot_d = VEC_ZERO;
        out_idx_d    = IDX_ZERO;
        out_last_d   = 1'b0;
`ifdef PRIORITY_DECODE_THERM_EN
        out_therm_d  = VEC_ZERO;
`endif
        if (emit_next_s) begin
            out_onehot_d = onehot_of(cur_d);
            out_idx_d    = cur_d;
            out_last_d   = (~walk_d) | (cur_d == IDX_ZERO);
`ifdef PRIORITY_DECODE_THERM_EN
            out_therm_d  = therm_of(cur_d);
`endif
        end else begin
            // Beat fields read as zero whenever no beat is presented.
            out_onehot_d = VEC_ZERO;
            out_idx_d    = IDX_ZERO;
            out_last_d   = 1'b0;
        end
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= IDX_ZERO;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            walk_q  <= walk_d;
        end
    end

    // Output registers; reset wins over any simultaneous handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_onehot_q <= VEC_ZERO;
            out_idx_q    <= IDX_ZERO;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef PRIORITY_DECODE_THERM_EN
            out_therm_q  <= VEC_ZERO;
`endif
        end else begin
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef PRIORITY_DECODE_THERM_EN
            out_therm_q  <= out_therm_d;
`endif
        end
    end

    // Port drive from the output registers.
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign err        = err_q;
`ifdef PRIORITY_DECODE_THERM_EN
    assign out_therm  = out_therm_q;
`endif

endmodule

// File: tb/tb_priority_decode.sv
// ============================================================================
// tb_priority_decode
// ----------------------------------------------------------------------------
// Self-checking bench for priority_decode. Expected beats are pushed to a
// scoreboard queue when a request is issued and popped as the DUT presents
// beats. Inputs change and outputs are sampled on the falling clock edge.
// ============================================================================
module tb_priority_decode;

    localparam int N = 255;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_idx;
    logic         in_walk;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_onehot;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         busy;
    logic         err;
`ifdef PRIORITY_DECODE_THERM_EN
    logic [N-1:0] out_therm;
`endif

    typedef struct {
        logic [N-1:0] onehot;
        logic [W-1:0] idx;
        logic         last;
        logic [N-1:0] therm;
    } exp_t;

    exp_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    priority_decode #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_walk    (in_walk),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
`ifdef PRIORITY_DECODE_THERM_EN
        .out_therm  (out_therm),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;

    // Expected beats for a request starting at index k.
    task automatic push_req(input int k, input bit walk);
        exp_t         e;
        logic [N:0]   wide;
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        for (int j = k; j >= 0; j--) begin
            wide     = ({1'b0, one} << (j + 1)) - {{N{1'b0}}, 1'b1};
            e.onehot = one << j;
            e.idx    = W'(j);
            e.last   = (!walk) || (j == 0);
            e.therm  = wide[N-1:0];
            exp_q.push_back(e);
            if (!walk) break;
        end
    endtask

    // Issue one request; called and returns on a falling edge.
    task automatic send(input int k, input bit walk);
        in_idx   = W'(k);
        in_walk  = walk;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a presented beat, capture it, step past its edge.
    task automatic get_beat(output bit got, output logic [N-1:0] oh,
                            output logic [W-1:0] ix, output logic la,
                            output logic [N-1:0] th);
        got = 1'b0;
        oh  = '0;
        ix  = '0;
        la  = 1'b0;
        th  = '0;
        for (int i = 0; i < 16 && !got; i++) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
                oh  = out_onehot;
                ix  = out_idx;
                la  = out_last;
`ifdef PRIORITY_DECODE_THERM_EN
                th  = out_therm;
`endif
            end
            @(negedge clk);
        end
    endtask

    // Highest set bit of n, as the encoder would report it.
    function automatic int msb_of(input logic [N-1:0] n);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (n[i]) r = i;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_walk   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            busy !== 1'b0 || err !== 1'b0 || out_onehot !== '0 || out_idx !== '0) begin
            tests_failed++;
            $display("FAIL reset: in_ready=%b out_valid=%b last=%b busy=%b err=%b idx=%0d, expected 1 0 0 0 0 0",
                     in_ready, out_valid, out_last, busy, err, out_idx);
        end
`ifdef PRIORITY_DECODE_THERM_EN
        tests_run++;
        if (out_therm !== '0) begin
            tests_failed++;
            $display("FAIL reset_therm: got %h, expected 0", out_therm);
        end
`endif
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        exp_t e;
        bit got;
        logic [N-1:0] oh, th;
        logic [W-1:0] ix;
        logic la;
        push_req(3, 1'b0);
        send(3, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_beat(got, oh, ix, la, th);
            tests_run++;
            if (!got || oh !== e.onehot || ix !== e.idx || la !== e.last) begin
                tests_failed++;
                $display("FAIL single beat: got valid=%0b idx=%0d last=%0b oh=%h, expected idx=%0d last=%0b oh=%h",
                         got, ix, la, oh, e.idx, e.last, e.onehot);
            end
        end
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_walk();
        exp_t e;
        bit got;
        logic [N-1:0] oh, th;
        logic [W-1:0] ix;
        logic la;
        push_req(3, 1'b1);
        send(3, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_beat(got, oh, ix, la, th);
            tests_run++;
            if (!got || oh !== e.onehot || ix !== e.idx || la !== e.last) begin
                tests_failed++;
                $display("FAIL walk beat: got valid=%0b idx=%0d last=%0b oh=%h, expected idx=%0d last=%0b oh=%h",
                         got, ix, la, oh, e.idx, e.last, e.onehot);
            end
`ifdef PRIORITY_DECODE_THERM_EN
            tests_run++;
            if (th !== e.therm) begin
                tests_failed++;
                $display("FAIL walk therm: got %h, expected %h", th, e.therm);
            end
`endif
        end
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL walk_end: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_boundary();
        exp_t e;
        bit got;
        logic [N-1:0] oh, th;
        logic [W-1:0] ix;
        logic la;
        int   kk[2] = '{254, 0};
        bit   ww[2] = '{1'b0, 1'b1};
        for (int t = 0; t < 2; t++) begin
            push_req(kk[t], ww[t]);
            send(kk[t], ww[t]);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                get_beat(got, oh, ix, la, th);
                tests_run++;
                if (!got || oh !== e.onehot || ix !== e.idx || la !== e.last) begin
                    tests_failed++;
                    $display("FAIL boundary beat: got valid=%0b idx=%0d last=%0b oh=%h, expected idx=%0d last=%0b oh=%h",
                             got, ix, la, oh, e.idx, e.last, e.onehot);
                end
            end
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL boundary_extra: out_valid=%b, expected 0", out_valid);
            end
        end
        // Index 255 is out of range: one err pulse, no beat, still ready.
        in_idx   = 8'd255;
        in_walk  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_pulse: err=%b out_valid=%b in_ready=%b busy=%b, expected 1 0 1 0",
                     err, out_valid, in_ready, busy);
        end
        @(negedge clk);
        tests_run++;
        if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_clear: err=%b out_valid=%b in_ready=%b, expected 0 0 1", err, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit got;
        logic [N-1:0] oh, th;
        logic [W-1:0] ix;
        logic la;
        out_ready = 1'b0;
        push_req(2, 1'b1);
        send(2, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_onehot !== exp_q[0].onehot || out_idx !== 8'd2 || out_last !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold: cycle %0d valid=%b idx=%0d last=%b oh=%h, expected 1 2 0 %h",
                         c, out_valid, out_idx, out_last, out_onehot, exp_q[0].onehot);
            end
            if (c < 3) begin
                // A request arriving during EMIT must be ignored.
                in_idx   = 8'd9;
                in_walk  = 1'b0;
                in_valid = 1'b1;
                @(negedge clk);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_beat(got, oh, ix, la, th);
            tests_run++;
            if (!got || oh !== e.onehot || ix !== e.idx || la !== e.last) begin
                tests_failed++;
                $display("FAIL bp beat: got valid=%0b idx=%0d last=%0b oh=%h, expected idx=%0d last=%0b oh=%h",
                         got, ix, la, oh, e.idx, e.last, e.onehot);
            end
        end
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_ignored: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_walk();
        exp_t e;
        bit got;
        logic [N-1:0] oh, th;
        logic [W-1:0] ix;
        logic la;
        push_req(19, 1'b1);
        send(19, 1'b1);
        for (int b = 0; b < 5; b++) begin
            e = exp_q.pop_front();
            get_beat(got, oh, ix, la, th);
            tests_run++;
            if (!got || oh !== e.onehot || ix !== e.idx || la !== e.last) begin
                tests_failed++;
                $display("FAIL rstwalk beat: got valid=%0b idx=%0d last=%0b oh=%h, expected idx=%0d last=%0b oh=%h",
                         got, ix, la, oh, e.idx, e.last, e.onehot);
            end
        end
        // Reset coincides with the handshake on the sixth beat.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_idx !== '0) begin
            tests_failed++;
            $display("FAIL rstwalk_state: out_valid=%b busy=%b in_ready=%b idx=%0d, expected 0 0 1 0",
                     out_valid, busy, in_ready, out_idx);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstwalk_nobeat: out_valid=%b, expected 0", out_valid);
        end
        push_req(7, 1'b0);
        send(7, 1'b0);
        e = exp_q.pop_front();
        get_beat(got, oh, ix, la, th);
        tests_run++;
        if (!got || oh !== e.onehot || ix !== e.idx || la !== e.last) begin
            tests_failed++;
            $display("FAIL rstwalk_new: got valid=%0b idx=%0d last=%0b oh=%h, expected idx=%0d last=%0b oh=%h",
                     got, ix, la, oh, e.idx, e.last, e.onehot);
        end
    endtask

    task automatic test_round_trip();
        exp_t e;
        bit got;
        logic [N-1:0] oh, th;
        logic [W-1:0] ix;
        logic la;
        logic [N-1:0] ns[6];
        int k;
        ns[0] = 255'hF;
        ns[1] = 255'hFF;
        ns[2] = 255'hFFF;
        ns[3] = 255'hFFFF;
        ns[4] = 255'hFFFFF;
        ns[5] = '1;
        for (int t = 0; t < 6; t++) begin
            k = msb_of(ns[t]);
            push_req(k, 1'b0);
            send(k, 1'b0);
            e = exp_q.pop_front();
            get_beat(got, oh, ix, la, th);
            tests_run++;
            if (!got || oh !== e.onehot || ix !== e.idx || la !== 1'b1) begin
                tests_failed++;
                $display("FAIL roundtrip n%0d: got valid=%0b idx=%0d last=%0b oh=%h, expected idx=%0d last=1 oh=%h",
                         t, got, ix, la, oh, e.idx, e.onehot);
            end
`ifdef PRIORITY_DECODE_THERM_EN
            tests_run++;
            if (th !== ns[t]) begin
                tests_failed++;
                $display("FAIL roundtrip therm n%0d: got %h, expected %h", t, th, ns[t]);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_walk();
        test_boundary();
        test_backpressure();
        test_reset_mid_walk();
        test_round_trip();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
